// File: rtl/xif_coproc_alu_if.sv
// ---------------------------------------------------------------------------
// xif_coproc_alu_if
// Issue, commit and result channels of the CORE-V-XIF between the core
// (master) and the custom-0 integer coprocessor (slave).
//   issue_*  : instruction offer, operands, accept/writeback answer
//   commit_* : commit or kill of a previously issued id
//   result_* : in-order result return with valid/ready handshake
// ---------------------------------------------------------------------------
interface xif_coproc_alu_if #(
    parameter int X_ID_WIDTH = 4
);
    logic                  issue_valid;
    logic                  issue_ready;
    logic [31:0]           issue_instr;
    logic [X_ID_WIDTH-1:0] issue_id;
    logic [31:0]           issue_rs0;
    logic [31:0]           issue_rs1;
    logic [1:0]            issue_rs_valid;
    logic                  issue_accept;
    logic                  issue_writeback;

    logic                  commit_valid;
    logic [X_ID_WIDTH-1:0] commit_id;
    logic                  commit_kill;

    logic                  result_valid;
    logic                  result_ready;
    logic [X_ID_WIDTH-1:0] result_id;
    logic [4:0]            result_rd;
    logic [31:0]           result_data;
    logic                  result_we;

    modport master (
        output issue_valid, issue_instr, issue_id, issue_rs0, issue_rs1, issue_rs_valid,
        output commit_valid, commit_id, commit_kill,
        output result_ready,
        input  issue_ready, issue_accept, issue_writeback,
        input  result_valid, result_id, result_rd, result_data, result_we
    );

    modport slave (
        input  issue_valid, issue_instr, issue_id, issue_rs0, issue_rs1, issue_rs_valid,
        input  commit_valid, commit_id, commit_kill,
        input  result_ready,
        output issue_ready, issue_accept, issue_writeback,
        output result_valid, result_id, result_rd, result_data, result_we
    );
endinterface

// File: rtl/xif_coproc_alu.sv
// ---------------------------------------------------------------------------
// xif_coproc_alu
// Coprocessor-side responder for a small set of custom-0 integer instructions
// (ABSDIFFU, MIN, MAX, HAMM). Accepted instructions are executed in the issue
// cycle and parked in a circular buffer until the core commits or kills them;
// committed results leave strictly in issue order.
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset
//   xif    : issue / commit / result channels (slave side)
//   busy_o : buffer holds at least one entry
// Entry states:
//   PENDING   | waiting for commit or kill from the core
//   COMMITTED | result may be returned once the entry reaches the head
//   KILLED    | dropped silently when it reaches the head
// ---------------------------------------------------------------------------
module xif_coproc_alu #(
    parameter int X_ID_WIDTH = 4,
    parameter int DEPTH      = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    xif_coproc_alu_if.slave xif,
    output logic            busy_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_PENDING   = 2'd0,
        ST_COMMITTED = 2'd1,
        ST_KILLED    = 2'd2
    } entry_state_t;

    logic [DEPTH-1:0]      ent_valid;
    entry_state_t          ent_state [DEPTH];
    logic [X_ID_WIDTH-1:0] ent_id    [DEPTH];
    logic [4:0]            ent_rd    [DEPTH];
    logic [31:0]           ent_data  [DEPTH];

    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count;

    // ---------------- decode ----------------
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       dec_accept;
    logic       full;
    logic       push;
    logic       unused_instr_bits;

    assign opcode = xif.issue_instr[6:0];
    assign funct3 = xif.issue_instr[14:12];
    assign funct7 = xif.issue_instr[31:25];
    assign unused_instr_bits = ^xif.issue_instr[24:15];

    // funct3[2] == 0 selects the four supported operations
    assign dec_accept = (opcode == 7'b0001011) && (funct7 == 7'd0) && !funct3[2];
    assign full       = (count == CNT_W'(DEPTH));

    assign xif.issue_ready     = !full && (!dec_accept || (xif.issue_rs_valid == 2'b11));
    assign xif.issue_accept    = xif.issue_valid && dec_accept;
    assign xif.issue_writeback = xif.issue_valid && dec_accept;

    assign push = xif.issue_valid && xif.issue_ready && dec_accept;

    // ---------------- execute ----------------
    logic [31:0] alu_result;
    logic [31:0] xor_val;
    logic [5:0]  pop_cnt;

    always_comb begin
        xor_val = xif.issue_rs0 ^ xif.issue_rs1;
        pop_cnt = '0;
        for (int i = 0; i < 32; i++) begin
            pop_cnt = pop_cnt + 6'(xor_val[i]);
        end
        alu_result = '0;
        case (funct3[1:0])
            2'b00: alu_result = (xif.issue_rs0 >= xif.issue_rs1) ?
                                (xif.issue_rs0 - xif.issue_rs1) :
                                (xif.issue_rs1 - xif.issue_rs0);
            2'b01: alu_result = ($signed(xif.issue_rs0) < $signed(xif.issue_rs1)) ?
                                xif.issue_rs0 : xif.issue_rs1;
            2'b10: alu_result = ($signed(xif.issue_rs0) > $signed(xif.issue_rs1)) ?
                                xif.issue_rs0 : xif.issue_rs1;
            default: alu_result = {26'd0, pop_cnt};
        endcase
    end

    // A commit arriving together with its own issue lands on the new entry.
    entry_state_t new_state;

    always_comb begin
        new_state = ST_PENDING;
        if (xif.commit_valid && (xif.commit_id == xif.issue_id)) begin
            new_state = xif.commit_kill ? ST_KILLED : ST_COMMITTED;
        end
    end

    // ---------------- head / result ----------------
    logic head_committed;
    logic head_killed;
    logic pop;

    assign head_committed = ent_valid[head_ptr] && (ent_state[head_ptr] == ST_COMMITTED);
    assign head_killed    = ent_valid[head_ptr] && (ent_state[head_ptr] == ST_KILLED);
    assign pop            = head_killed || (head_committed && xif.result_ready);

    // Result fields are driven only from registered head state, zero when idle.
    assign xif.result_valid = head_committed;
    assign xif.result_we    = head_committed;
    assign xif.result_id    = head_committed ? ent_id[head_ptr]   : '0;
    assign xif.result_rd    = head_committed ? ent_rd[head_ptr]   : '0;
    assign xif.result_data  = head_committed ? ent_data[head_ptr] : '0;

    assign busy_o = (count != '0);

    // ---------------- buffer state ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_ptr  <= '0;
            tail_ptr  <= '0;
            count     <= '0;
            ent_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_state[i] <= ST_PENDING;
                ent_id[i]    <= '0;
                ent_rd[i]    <= '0;
                ent_data[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (xif.commit_valid && ent_valid[i] && (ent_state[i] == ST_PENDING) &&
                    (ent_id[i] == xif.commit_id)) begin
                    ent_state[i] <= xif.commit_kill ? ST_KILLED : ST_COMMITTED;
                end
            end

            // head and tail never alias here: pop needs count > 0, push needs count < DEPTH
            if (pop) begin
                ent_valid[head_ptr] <= 1'b0;
                head_ptr            <= head_ptr + PTR_W'(1);
            end

            if (push) begin
                ent_valid[tail_ptr] <= 1'b1;
                ent_state[tail_ptr] <= new_state;
                ent_id[tail_ptr]    <= xif.issue_id;
                ent_rd[tail_ptr]    <= xif.issue_instr[11:7];
                ent_data[tail_ptr]  <= alu_result;
                tail_ptr            <= tail_ptr + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_xif_coproc_alu.sv
// ---------------------------------------------------------------------------
// tb_xif_coproc_alu
// Directed bench for xif_coproc_alu. Expected results are queued when an
// instruction is issued; a monitor pops and compares them as the DUT returns
// results. Killed entries are marked in the queue and skipped.
// ---------------------------------------------------------------------------
module tb_xif_coproc_alu;
    localparam int IDW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [IDW-1:0] id;
        logic [4:0]     rd;
        logic [31:0]    data;
        bit             killed;
    } exp_t;

    exp_t sb[$];

    xif_coproc_alu_if #(.X_ID_WIDTH(IDW)) xif ();

    xif_coproc_alu #(.X_ID_WIDTH(IDW), .DEPTH(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .xif   (xif),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3,
                                             input logic [4:0] rd, input logic [6:0] op);
        return {f7, 5'd2, 5'd1, f3, rd, op};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: one comparison set per completed result transfer.
    always @(negedge clk) begin
        if (!rst && xif.result_valid && xif.result_ready) begin
            while (sb.size() > 0 && sb[0].killed) void'(sb.pop_front());
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_result: observed id 0x%0h expected no result", xif.result_id);
            end
            if (sb.size() > 0) begin
                check("result_id", 32'(xif.result_id), 32'(sb[0].id));
                check("result_rd", 32'(xif.result_rd), 32'(sb[0].rd));
                check("result_data", xif.result_data, sb[0].data);
                check("result_we", 32'(xif.result_we), 32'd1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_op(input logic [2:0] f3, input logic [IDW-1:0] id, input logic [4:0] rd,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_data, input bit commit_now);
        exp_t e;
        xif.issue_valid    = 1'b1;
        xif.issue_instr    = mk_instr(7'd0, f3, rd, 7'b0001011);
        xif.issue_id       = id;
        xif.issue_rs0      = a;
        xif.issue_rs1      = b;
        xif.issue_rs_valid = 2'b11;
        if (commit_now) begin
            xif.commit_valid = 1'b1;
            xif.commit_id    = id;
            xif.commit_kill  = 1'b0;
        end
        #1;
        check("issue_accept", 32'(xif.issue_accept), 32'd1);
        check("issue_writeback", 32'(xif.issue_writeback), 32'd1);
        check("issue_ready", 32'(xif.issue_ready), 32'd1);
        e.id = id; e.rd = rd; e.data = exp_data; e.killed = 1'b0;
        sb.push_back(e);
        step();
        xif.issue_valid  = 1'b0;
        xif.commit_valid = 1'b0;
    endtask

    task automatic issue_reject(input string tag, input logic [31:0] instr);
        xif.issue_valid    = 1'b1;
        xif.issue_instr    = instr;
        xif.issue_rs_valid = 2'b00;
        #1;
        check({tag, "_accept"}, 32'(xif.issue_accept), 32'd0);
        check({tag, "_writeback"}, 32'(xif.issue_writeback), 32'd0);
        check({tag, "_ready"}, 32'(xif.issue_ready), 32'd1);
        step();
        xif.issue_valid = 1'b0;
        @(negedge clk);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic commit(input logic [IDW-1:0] id, input bit kill);
        xif.commit_valid = 1'b1;
        xif.commit_id    = id;
        xif.commit_kill  = kill;
        if (kill) begin
            foreach (sb[i]) if (sb[i].id == id && !sb[i].killed) sb[i].killed = 1'b1;
        end
        step();
        xif.commit_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        int live = 0;
        while (busy && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check("drain_busy", 32'(busy), 32'd0);
        foreach (sb[i]) if (!sb[i].killed) live++;
        check("drain_pending", 32'(live), 32'd0);
        sb.delete();
        step();
    endtask

    initial begin
        xif.issue_valid    = 1'b0;
        xif.issue_instr    = '0;
        xif.issue_id       = '0;
        xif.issue_rs0      = '0;
        xif.issue_rs1      = '0;
        xif.issue_rs_valid = 2'b11;
        xif.commit_valid   = 1'b0;
        xif.commit_id      = '0;
        xif.commit_kill    = 1'b0;
        xif.result_ready   = 1'b0;

        // reset then idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_result_valid", 32'(xif.result_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_issue_ready", 32'(xif.issue_ready), 32'd1);
        check("rst_result_data", xif.result_data, 32'd0);
        check("rst_result_id", 32'(xif.result_id), 32'd0);

        // MAX(-2, 3) = 3 committed in the issue cycle, then held 3 cycles
        issue_op(3'b010, 4'd5, 5'd10, 32'hFFFF_FFFE, 32'd3, 32'd3, 1'b1);
        @(negedge clk);
        check("max_valid", 32'(xif.result_valid), 32'd1);
        for (int c = 0; c < 3; c++) begin
            check("hold_valid", 32'(xif.result_valid), 32'd1);
            check("hold_id", 32'(xif.result_id), 32'd5);
            check("hold_rd", 32'(xif.result_rd), 32'd10);
            check("hold_data", xif.result_data, 32'd3);
            @(negedge clk);
        end
        step();
        xif.result_ready = 1'b1;
        step();
        xif.result_ready = 1'b0;
        @(negedge clk);
        check("max_popped_valid", 32'(xif.result_valid), 32'd0);
        check("max_popped_busy", 32'(busy), 32'd0);

        // rejected encodings
        issue_reject("rej_op33", mk_instr(7'd0, 3'b000, 5'd4, 7'h33));
        issue_reject("rej_f3_100", mk_instr(7'd0, 3'b100, 5'd4, 7'b0001011));
        issue_reject("rej_f7", mk_instr(7'd1, 3'b001, 5'd4, 7'b0001011));

        // accepted instruction with incomplete operands is not ready
        xif.issue_valid    = 1'b1;
        xif.issue_instr    = mk_instr(7'd0, 3'b001, 5'd4, 7'b0001011);
        xif.issue_rs_valid = 2'b01;
        #1;
        check("rs_invalid_ready", 32'(xif.issue_ready), 32'd0);
        step();
        xif.issue_valid = 1'b0;
        @(negedge clk);
        check("rs_invalid_busy", 32'(busy), 32'd0);

        // out-of-order commit/kill, in-order results
        xif.result_ready = 1'b1;
        issue_op(3'b000, 4'd1, 5'd1, 32'd5, 32'd9, 32'd4, 1'b0);
        issue_op(3'b011, 4'd2, 5'd2, 32'h0000_00F0, 32'h0000_000F, 32'd8, 1'b0);
        issue_op(3'b001, 4'd3, 5'd3, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0);
        commit(4'd3, 1'b0);
        @(negedge clk);
        check("order_stall_valid", 32'(xif.result_valid), 32'd0);
        commit(4'd2, 1'b1);
        commit(4'd1, 1'b0);
        wait_drain(20);

        // fill to full, pop one, ready comes back the cycle after the pop
        issue_op(3'b000, 4'd8, 5'd8, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        issue_op(3'b011, 4'd9, 5'd9, 32'd0, 32'hFFFF_FFFF, 32'd32, 1'b0);
        issue_op(3'b010, 4'd10, 5'd11, 32'hFFFF_FFFB, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 1'b0);
        issue_op(3'b001, 4'd11, 5'd12, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 1'b0);
        xif.issue_instr    = mk_instr(7'd0, 3'b010, 5'd1, 7'b0001011);
        xif.issue_rs_valid = 2'b11;
        #1;
        check("full_ready", 32'(xif.issue_ready), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
        commit(4'd8, 1'b0);
        @(negedge clk);
        check("full_pop_cycle_ready", 32'(xif.issue_ready), 32'd0);
        check("full_pop_cycle_valid", 32'(xif.result_valid), 32'd1);
        @(negedge clk);
        check("after_pop_ready", 32'(xif.issue_ready), 32'd1);
        check("after_pop_busy", 32'(busy), 32'd1);
        step();
        commit(4'd9, 1'b0);
        commit(4'd10, 1'b0);
        commit(4'd11, 1'b0);
        wait_drain(20);

        // unknown id, then reset with three pending entries
        issue_op(3'b000, 4'd12, 5'd1, 32'd1, 32'd2, 32'd1, 1'b0);
        issue_op(3'b000, 4'd13, 5'd2, 32'd3, 32'd2, 32'd1, 1'b0);
        issue_op(3'b000, 4'd14, 5'd3, 32'd7, 32'd2, 32'd5, 1'b0);
        commit(4'd7, 1'b0);
        @(negedge clk);
        check("unknown_busy", 32'(busy), 32'd1);
        check("unknown_valid", 32'(xif.result_valid), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(xif.result_valid), 32'd0);
        sb.delete();
        step();
        step();
        rst = 1'b0;
        commit(4'd12, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("postrst_valid", 32'(xif.result_valid), 32'd0);
            check("postrst_busy", 32'(busy), 32'd0);
        end

        // fresh traffic after reset
        step();
        issue_op(3'b000, 4'd1, 5'd7, 32'd9, 32'd5, 32'd4, 1'b1);
        wait_drain(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/xif_coproc_alu.md
# xif_coproc_alu

Coprocessor-side (responder) end of the CORE-V-XIF used by the cv32e40px core in core-v-mini-mcu. It answers issue requests for a small set of custom-0 integer instructions, holds accepted instructions until the core commits or kills them, and returns results in issue order through the result interface. It connects to the issue, commit and result channels of the CPU-side XIF ports. The compressed, mem and mem_result channels are tied off by the integrator.

## Interface
Parameters:
- X_ID_WIDTH, 4, width of instruction id.
- DEPTH, 4, pending-instruction buffer entries (power of two, ≥2).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- issue_valid_i  in  1  core offers instruction.
- issue_ready_o  out  1  coprocessor can take handshake this cycle.
- issue_instr_i  in  32  instruction word.
- issue_id_i  in  X_ID_WIDTH  instruction id.
- issue_rs0_i / issue_rs1_i  in  32 each  source operands.
- issue_rs_valid_i  in  2  operand valid bits.
- issue_accept_o  out  1  instruction is ours (valid during handshake).
- issue_writeback_o  out  1  will write rd (equals accept).
- commit_valid_i  in  1  commit/kill event.
- commit_id_i  in  X_ID_WIDTH  id being committed.
- commit_kill_i  in  1  1 = kill, 0 = commit.
- result_valid_o  out  1  result available.
- result_ready_i  in  1  core takes result.
- result_id_o  out  X_ID_WIDTH  id of result.
- result_rd_o  out  5  destination register.
- result_data_o  out  32  result value.
- result_we_o  out  1  write enable (always 1 when valid).
- busy_o  out  1  buffer non-empty.

## Operation
- Decode (combinational on issue_instr_i): accepted iff opcode = 7'b0001011 and funct7 = 0 and funct3 ∈ {000, 001, 010, 011}. All other encodings are rejected.
- Operations:
  - 000 ABSDIFFU: |rs0 − rs1|, unsigned.
  - 001 MIN: signed min.
  - 010 MAX: signed max.
  - 011 HAMM: popcount(rs0 ^ rs1), zero-extended to 32 bits.
- issue_ready_o = !full && (!accept || issue_rs_valid_i == 2'b11). Rejected instructions are ready whenever not full.
- Handshake = issue_valid_i && issue_ready_o.
  - Rejected handshake allocates nothing; accept = writeback = 0.
- Accepted handshake writes a circular FIFO entry at the tail: {id, rd = instr[11:7], data = computed result, state = PENDING}.
  - The result is computed in the issue cycle and stored.
- Commit handling: on commit_valid_i, search all valid entries for state PENDING with id == commit_id_i.
  - Kill sets state KILLED.
  - Commit sets state COMMITTED.
  - No match: event ignored, no error.
- An issue handshake and a commit for the same id in the same cycle apply the commit to the new entry.
- Head processing, each cycle:
  - Head COMMITTED: result_valid_o = 1 with the head fields. Pop on result_ready_i.
  - Head KILLED: popped silently, no result_valid_o.
  - Head PENDING: stall. Later committed entries wait; results are strictly in issue order.
- Simultaneous push and pop allowed; count is unchanged. Pointers wrap modulo DEPTH.

## Timing
- All state resets asynchronously on rst_i.
  - Reset values: count = 0, pointers = 0, all entries invalid.
  - result_valid_o = 0, busy_o = 0, result_id_o / rd / data = 0.
- issue_ready_o, issue_accept_o and issue_writeback_o are combinational from the issue inputs and count.
- result_* outputs come from registered FIFO head state, with no combinational path from issue/commit inputs.
- Latency:
  - Issue at cycle T with commit also at T → result_valid_o at T+1.
  - Commit at T+k (k ≥ 0) → result_valid_o at T+k+1 if the entry is at the head.
- Result hold: while result_valid_o && !result_ready_i, all result_* outputs stay stable.
- Killed head: removed in 1 cycle; the next entry may present in the following cycle.
- Full (count = DEPTH): issue_ready_o = 0. A pop in the same cycle does not relieve full until the next cycle.
- rst_i asserted mid-operation discards all pending entries immediately; no result is emitted for them.

## Test plan
- Reset then idle: result_valid_o = 0, busy_o = 0, issue_ready_o = 1 with rs_valid = 2'b11.
- Issue MAX (funct3 = 010), rs0 = 0xFFFFFFFE, rs1 = 3, id = 5, rd = 10, committed the same cycle → next cycle result_valid_o = 1, id = 5, rd = 10, data = 3. Hold 3 cycles with result_ready_i = 0 and check outputs stay stable.
- Issue an encoding with opcode 0x33 → accept = 0, writeback = 0, busy_o remains 0.
- Issue ids 1, 2, 3 (ABSDIFFU 5,9; HAMM 0xF0,0x0F; MIN −1,1); commit 3, kill 2, commit 1 → results appear in order: id 1 = 4, then id 3 = 0xFFFFFFFF. No result for id 2.
- Fill 4 entries without commit → issue_ready_o = 0, busy_o = 1. Commit the head and pop it → issue_ready_o returns to 1 one cycle after the pop.
- Commit with an unknown id 7 → no state change. Assert rst_i with 3 pending entries → busy_o = 0 and no results emitted afterwards.
